// File: rtl/object_scheduler.sv
// -----------------------------------------------------------------------------
// object_scheduler
//
// Walks the object buffer once per frame and hands each object to the
// rasterizer over a valid/ready handshake.
//
// Configuration macro:
//   OBJECT_SCHEDULER_CULL_EN - when defined, objects with depth == 0 are
//                              skipped in FETCH (read past, never presented,
//                              never counted).
//
// Ports:
//   clock          in   sole clock, rising edge
//   reset          in   asynchronous, active-low
//   frame_start    in   single-cycle pulse requesting a frame pass
//   buf_next_frame out  rewinds the buffer read cursor (one cycle, REWIND)
//   buf_read       out  advances the buffer read cursor (FETCH)
//   buf_data       in   object at the buffer read cursor (combinational)
//   buf_read_end   in   buffer read cursor equals write cursor
//   obj            out  object presented to the rasterizer
//   obj_valid      out  obj is valid (PRESENT)
//   obj_ready      in   rasterizer accepts obj this cycle
//   frame_done     out  single-cycle pulse at end of pass (DONE)
//   object_count   out  objects accepted in the current or last pass
//   overrun        out  sticky: frame_start seen while not IDLE
//   state_dbg      out  current FSM state for debug/checkers
//
// Handshake: obj is transferred on a rising edge where obj_valid and
// obj_ready are both 1. obj_valid never drops and obj never changes until
// that transfer happens; obj_ready while obj_valid is 0 has no effect.
// -----------------------------------------------------------------------------
package object_scheduler_pkg;
  typedef struct packed {
    logic [7:0] depth;
    logic [7:0] color;
    logic [7:0] y;
    logic [7:0] x;
  } object_t;
endpackage

module object_scheduler
  import object_scheduler_pkg::*;
#(
  parameter int SIZE = 50
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      frame_start,
  output logic                      buf_next_frame,
  output logic                      buf_read,
  input  object_t                   buf_data,
  input  logic                      buf_read_end,
  output object_t                   obj,
  output logic                      obj_valid,
  input  logic                      obj_ready,
  output logic                      frame_done,
  output logic [$clog2(SIZE+1)-1:0] object_count,
  output logic                      overrun,
  output logic [2:0]                state_dbg
);

  localparam int CW = $clog2(SIZE+1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REWIND  = 3'd1,
    S_FETCH   = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state, state_next;
  logic   full;
  logic   fetch_end;
  logic   cull;
  logic   load_obj;

  // The pass ends either when the buffer runs dry or when the frame quota
  // is reached; in the latter case the remaining objects are left unread.
  assign full      = (object_count == CW'(SIZE));
  assign fetch_end = buf_read_end || full;

`ifdef OBJECT_SCHEDULER_CULL_EN
  assign cull = (buf_data.depth == 8'd0);
`else
  assign cull = 1'b0;
`endif

  always_comb begin
    state_next     = state;
    buf_next_frame = 1'b0;
    buf_read       = 1'b0;
    obj_valid      = 1'b0;
    frame_done     = 1'b0;
    load_obj       = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_start) state_next = S_REWIND;
      end
      S_REWIND: begin
        buf_next_frame = 1'b1;
        state_next     = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_end) begin
          state_next = S_DONE;
        end else begin
          // A culled object is read past and FETCH retries on the next one.
          buf_read = 1'b1;
          if (!cull) begin
            load_obj   = 1'b1;
            state_next = S_PRESENT;
          end
        end
      end
      S_PRESENT: begin
        obj_valid = 1'b1;
        if (obj_ready) state_next = S_FETCH;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      obj          <= '0;
      object_count <= '0;
      overrun      <= 1'b0;
    end else begin
      state <= state_next;
      if (load_obj) obj <= buf_data;
      if (state == S_IDLE && frame_start)
        object_count <= '0;
      else if (state == S_PRESENT && obj_ready && !full)
        object_count <= object_count + CW'(1);
      if (frame_start && state != S_IDLE) overrun <= 1'b1;
    end
  end

  assign state_dbg = state;

endmodule
